sys_arr_ctrl: RTL and testbench

- Sequencer for the MxM int8 systolic array (`sys_arr`). It buffers matrices A and B, loaded one row per beat, and clears the array. It then streams diagonally skewed, zero-padded operand lanes into the array, waits for accumulation to settle, and captures the packed C result behind a valid/ready output handshake.
- Sits between the host/DMA load path and `sys_arr`, and owns all of the array's control inputs.

---
 rtl/sys_arr_pkg.sv | 30 +++
 rtl/sys_arr_skew.sv | 35 +++
 rtl/sys_arr_ctrl.sv | 110 +++++++++++
 tb/tb_sys_arr_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_arr_pkg.sv
// sys_arr_pkg: shared types and sizing helpers for the
// systolic-array sequencer.
package sys_arr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    FEED,
    DRAIN,
    HOLD
  } state_t;

  localparam int DATA_W = 8;
  localparam int ACC_W  = 16;

  localparam int M_DEF       = 3;
  localparam int ACC_LAT_DEF = 1;

  function automatic int feed_cyc(input int m);
    return 3*m - 2;
  endfunction

  function automatic int cnt_w(input int m, input int lat);
    return $clog2(3*m + lat);
  endfunction

  localparam int FEED_CYC = feed_cyc(M_DEF);
  localparam int CNT_W    = cnt_w(M_DEF, ACC_LAT_DEF);

endpackage

// File: rtl/sys_arr_skew.sv
// sys_arr_skew: diagonal skew of buffered A rows / B
// columns onto the array lanes for feed step t.
module sys_arr_skew
  import sys_arr_pkg::*;
#(
  parameter int M  = M_DEF,
  parameter int CW = CNT_W
) (
  input  logic [DATA_W*M-1:0] buf_a [M],
  input  logic [DATA_W*M-1:0] buf_b [M],
  input  logic [CW-1:0]       t,
  input  logic                feed_en,
  output logic [DATA_W*M-1:0] arr_a,
  output logic [DATA_W*M-1:0] arr_b
);

  // Lane i carries element k of its row/column when t == i + k.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    if (feed_en) begin
      for (int i = 0; i < M; i++) begin
        for (int k = 0; k < M; k++) begin
          if (32'(t) == 32'(i + k)) begin
            arr_a[DATA_W*i +: DATA_W] =
              buf_a[i][DATA_W*k +: DATA_W];
            arr_b[DATA_W*i +: DATA_W] =
              buf_b[k][DATA_W*i +: DATA_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/sys_arr_ctrl.sv
// sys_arr_ctrl: load/clear/feed/drain/hold sequencer
// for the MxM int8 output-stationary systolic array.
module sys_arr_ctrl
  import sys_arr_pkg::*;
#(
  parameter int M       = M_DEF,
  parameter int ACC_LAT = ACC_LAT_DEF
) (
  input  logic                     CLK,
  input  logic                     rst_n,
  input  logic                     ld_vld,
  output logic                     ld_rdy,
  input  logic                     ld_sel,
  input  logic [$clog2(M)-1:0]     ld_row,
  input  logic [DATA_W*M-1:0]      ld_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     res_vld,
  input  logic                     res_rdy,
  output logic [ACC_W*M*M-1:0]     res_data,
  output logic                     arr_rst,
  output logic                     arr_vld_in,
  output logic                     arr_rdy_out,
  output logic [DATA_W*M-1:0]      arr_a,
  output logic [DATA_W*M-1:0]      arr_b,
  input  logic [ACC_W*M*M-1:0]     arr_c
);

  localparam int FC = feed_cyc(M);
  localparam int CW = cnt_w(M, ACC_LAT);

  localparam logic [CW-1:0] FEED_LAST  = CW'(FC - 1);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(ACC_LAT - 1);

  state_t              state;
  state_t              nxt;
  logic [CW-1:0]       cnt;
  logic [DATA_W*M-1:0] buf_a [M];
  logic [DATA_W*M-1:0] buf_b [M];
  logic                ld_fire;
  logic                feed_en;

  assign ld_rdy      = (state == IDLE);
  assign busy        = (state != IDLE);
  assign res_vld     = (state == HOLD);
  assign arr_rst     = (state == CLR);
  assign feed_en     = (state == FEED);
  assign arr_vld_in  = (state == FEED) || (state == DRAIN);
  assign arr_rdy_out = arr_vld_in;

  // start wins over a same-cycle load beat.
  assign ld_fire = ld_vld && ld_rdy && !start
                && (32'(ld_row) < 32'(M));

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start) nxt = CLR;
      CLR:   nxt = FEED;
      FEED:  if (cnt == FEED_LAST) nxt = DRAIN;
      DRAIN: if (cnt == DRAIN_LAST) nxt = HOLD;
      HOLD:  if (res_rdy) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      if (nxt != state) cnt <= '0;
      else if (arr_vld_in) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < M; r++) begin
        buf_a[r] <= '0;
        buf_b[r] <= '0;
      end
    end else if (ld_fire) begin
      if (ld_sel) buf_b[ld_row] <= ld_data;
      else        buf_a[ld_row] <= ld_data;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      res_data <= '0;
    end else if (state == DRAIN && cnt == DRAIN_LAST) begin
      res_data <= arr_c;
    end
  end

  sys_arr_skew #(
    .M  (M),
    .CW (CW)
  ) u_skew (
    .buf_a   (buf_a),
    .buf_b   (buf_b),
    .t       (cnt),
    .feed_en (feed_en),
    .arr_a   (arr_a),
    .arr_b   (arr_b)
  );

endmodule

// File: tb/tb_sys_arr_ctrl.sv
// tb_sys_arr_ctrl: drives sys_arr_ctrl against a cycle model
// of the systolic array and a plain matrix-product reference.
module tb_sys_arr_ctrl;

  localparam int M  = 3;
  localparam int RW = 16*M*M;

  logic          CLK;
  logic          rst_n;
  logic          ld_vld;
  logic          ld_rdy;
  logic          ld_sel;
  logic [1:0]    ld_row;
  logic [23:0]   ld_data;
  logic          start;
  logic          busy;
  logic          res_vld;
  logic          res_rdy;
  logic [RW-1:0] res_data;
  logic          arr_rst;
  logic          arr_vld_in;
  logic          arr_rdy_out;
  logic [23:0]   arr_a;
  logic [23:0]   arr_b;
  logic [RW-1:0] arr_c;

  int n_chk;
  int n_pass;

  int unsigned sa [M][M];
  int unsigned sb [M][M];

  sys_arr_ctrl #(.M(3), .ACC_LAT(1)) dut (
    .CLK         (CLK),
    .rst_n       (rst_n),
    .ld_vld      (ld_vld),
    .ld_rdy      (ld_rdy),
    .ld_sel      (ld_sel),
    .ld_row      (ld_row),
    .ld_data     (ld_data),
    .start       (start),
    .busy        (busy),
    .res_vld     (res_vld),
    .res_rdy     (res_rdy),
    .res_data    (res_data),
    .arr_rst     (arr_rst),
    .arr_vld_in  (arr_vld_in),
    .arr_rdy_out (arr_rdy_out),
    .arr_a       (arr_a),
    .arr_b       (arr_b),
    .arr_c       (arr_c)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Output-stationary array: a flows right, b flows down.
  logic [7:0]  pa  [M][M];
  logic [7:0]  pb  [M][M];
  logic [15:0] acc [M][M];

  function automatic logic [15:0] mul8(input logic [7:0] x,
                                       input logic [7:0] y);
    return 16'(x) * 16'(y);
  endfunction

  always_ff @(posedge CLK) begin
    if (arr_rst) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++) begin
          pa[i][j]  <= '0;
          pb[i][j]  <= '0;
          acc[i][j] <= '0;
        end
    end else if (arr_vld_in && arr_rdy_out) begin
      for (int i = 0; i < M; i++)
        for (int j = 0; j < M; j++) begin
          pa[i][j] <= (j == 0) ? arr_a[8*i +: 8]
                               : pa[i][(j == 0) ? 0 : j-1];
          pb[i][j] <= (i == 0) ? arr_b[8*j +: 8]
                               : pb[(i == 0) ? 0 : i-1][j];
          acc[i][j] <= acc[i][j] + mul8(
            (j == 0) ? arr_a[8*i +: 8] : pa[i][(j == 0) ? 0 : j-1],
            (i == 0) ? arr_b[8*j +: 8] : pb[(i == 0) ? 0 : i-1][j]);
        end
    end
  end

  always_comb begin
    arr_c = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++)
        arr_c[16*(M*M-1-(i*M+j)) +: 16] = acc[i][j];
  end

  function automatic logic [RW-1:0] expect_c();
    logic [RW-1:0] r;
    int unsigned s;
    r = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        s = 0;
        for (int k = 0; k < M; k++) s += sa[i][k] * sb[k][j];
        r[16*(M*M-1-(i*M+j)) +: 16] = s[15:0];
      end
    return r;
  endfunction

  task automatic clear_shadow();
    for (int i = 0; i < M; i++)
      for (int j = 0; j < M; j++) begin
        sa[i][j] = 0;
        sb[i][j] = 0;
      end
  endtask

  task automatic load(input logic sel, input int row,
                      input logic [23:0] d);
    @(negedge CLK);
    ld_vld  = 1'b1;
    ld_sel  = sel;
    ld_row  = 2'(row);
    ld_data = d;
    @(posedge CLK);
    #1 ld_vld = 1'b0;
    if (row < M)
      for (int k = 0; k < M; k++)
        if (sel) sb[row][k] = d[8*k +: 8];
        else     sa[row][k] = d[8*k +: 8];
  endtask

  task automatic load_rand();
    for (int r = 0; r < M; r++) begin
      load(1'b0, r, 24'($urandom));
      load(1'b1, r, 24'($urandom));
    end
  endtask

  task automatic run_job(output int lat, output int nrst,
                         output logic seq,
                         output logic [RW-1:0] data);
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    lat  = -1;
    nrst = arr_rst ? 1 : 0;
    seq  = arr_rst;
    for (int e = 1; e <= 40; e++) begin
      @(posedge CLK);
      #1;
      if (arr_rst) nrst++;
      if (e == 1) seq = seq && arr_vld_in && !arr_rst;
      if (res_vld) begin
        lat = e;
        break;
      end
    end
    data = res_data;
  endtask

  task automatic finish_job();
    @(negedge CLK);
    res_rdy = 1'b1;
    @(posedge CLK);
    #1 res_rdy = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge CLK);
    n_chk++;
    if ({ld_rdy, busy, res_vld, arr_rst, arr_vld_in, arr_rdy_out}
        !== 6'b100000)
      $display("FAIL reset_ctrl: got %b want 100000",
               {ld_rdy, busy, res_vld, arr_rst, arr_vld_in,
                arr_rdy_out});
    else n_pass++;
    n_chk++;
    if ({arr_a, arr_b} !== 48'h0)
      $display("FAIL reset_lanes: got %h want 0", {arr_a, arr_b});
    else n_pass++;
    n_chk++;
    if (res_data !== '0)
      $display("FAIL reset_res: got %h want 0", res_data);
    else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int lat, nrst;
    logic seq;
    logic [RW-1:0] d;
    load(1'b0, 0, 24'h000001);
    load(1'b0, 1, 24'h000100);
    load(1'b0, 2, 24'h010000);
    load(1'b1, 0, 24'h030201);
    load(1'b1, 1, 24'h060504);
    load(1'b1, 2, 24'h090807);
    run_job(lat, nrst, seq, d);
    n_chk++;
    if (lat !== 9) $display("FAIL id_latency: got %0d want 9", lat);
    else n_pass++;
    n_chk++;
    if (nrst !== 1 || seq !== 1'b1)
      $display("FAIL id_clr: got rst=%0d seq=%b want 1 1", nrst, seq);
    else n_pass++;
    n_chk++;
    if (d !== expect_c())
      $display("FAIL id_result: got %h want %h", d, expect_c());
    else n_pass++;
    n_chk++;
    if (d[RW-1 -: 16] !== 16'd1 || d[15:0] !== 16'd9)
      $display("FAIL id_packing: got %h/%h want 0001/0009",
               d[RW-1 -: 16], d[15:0]);
    else n_pass++;
    finish_job();
    n_chk++;
    if ({ld_rdy, busy, res_vld} !== 3'b100)
      $display("FAIL id_release: got %b want 100",
               {ld_rdy, busy, res_vld});
    else n_pass++;
  endtask

  task automatic test_wrap();
    int lat, nrst;
    logic seq;
    logic [RW-1:0] d, want;
    for (int r = 0; r < M; r++) begin
      load(1'b0, r, 24'hFFFFFF);
      load(1'b1, r, 24'hFFFFFF);
    end
    for (int e = 0; e < M*M; e++) want[16*e +: 16] = 16'hFA03;
    run_job(lat, nrst, seq, d);
    n_chk++;
    if (d !== want || d !== expect_c())
      $display("FAIL wrap_result: got %h want %h", d, want);
    else n_pass++;
    finish_job();
  endtask

  task automatic test_hold();
    int lat, nrst;
    logic seq;
    logic [RW-1:0] d;
    run_job(lat, nrst, seq, d);
    for (int c = 0; c < 5; c++) begin
      @(negedge CLK);
      start = (c % 2 == 0);
      @(posedge CLK);
      #1 start = 1'b0;
      n_chk++;
      if (res_vld !== 1'b1 || res_data !== expect_c())
        $display("FAIL hold_stable: got vld=%b %h want 1 %h",
                 res_vld, res_data, expect_c());
      else n_pass++;
    end
    finish_job();
    n_chk++;
    if ({ld_rdy, busy, res_vld} !== 3'b100)
      $display("FAIL hold_release: got %b want 100",
               {ld_rdy, busy, res_vld});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int lat, nrst;
    logic seq;
    logic [RW-1:0] d, want;
    load_rand();
    @(negedge CLK);
    start = 1'b1;
    @(posedge CLK);
    #1 start = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    n_chk++;
    if (arr_vld_in !== 1'b1)
      $display("FAIL mid_in_feed: got %b want 1", arr_vld_in);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({ld_rdy, busy, res_vld, arr_rst, arr_vld_in} !== 5'b10000
        || {arr_a, arr_b} !== 48'h0 || res_data !== '0)
      $display("FAIL mid_reset: got %b %h want 10000 0",
               {ld_rdy, busy, res_vld, arr_rst, arr_vld_in},
               {arr_a, arr_b});
    else n_pass++;
    @(negedge CLK);
    rst_n = 1'b1;
    clear_shadow();
    for (int r = 0; r < M; r++) begin
      load(1'b0, r, 24'h010101);
      load(1'b1, r, 24'h010101);
    end
    for (int e = 0; e < M*M; e++) want[16*e +: 16] = 16'd3;
    run_job(lat, nrst, seq, d);
    n_chk++;
    if (d !== want || d !== expect_c())
      $display("FAIL mid_rerun: got %h want %h", d, want);
    else n_pass++;
    finish_job();
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, nr1, nr2;
    logic s1, s2;
    logic [RW-1:0] d1, d2;
    load_rand();
    run_job(lat1, nr1, s1, d1);
    finish_job();
    run_job(lat2, nr2, s2, d2);
    n_chk++;
    if (d1 !== expect_c())
      $display("FAIL b2b_first: got %h want %h", d1, expect_c());
    else n_pass++;
    n_chk++;
    if (d2 !== expect_c() || lat2 !== 9)
      $display("FAIL b2b_second: got %h lat %0d want %h lat 9",
               d2, lat2, expect_c());
    else n_pass++;
    n_chk++;
    if (nr1 !== 1 || nr2 !== 1 || !s1 || !s2)
      $display("FAIL b2b_clr: got %0d %0d %b %b want 1 1 1 1",
               nr1, nr2, s1, s2);
    else n_pass++;
    finish_job();
  endtask

  task automatic test_skew();
    logic [23:0] wa, wb;
    load_rand();
    wa = {8'h00, 8'(sa[1][0]), 8'(sa[0][1])};
    wb = {8'h00, 8'(sb[0][1]), 8'(sb[1][0])};
    @(negedge CLK);
    start   = 1'b1;
    ld_vld  = 1'b1;
    ld_sel  = 1'b0;
    ld_row  = 2'd0;
    ld_data = ~24'(sa[0][0]) ^ 24'h5A5A5A;
    @(posedge CLK);
    #1 start = 1'b0;
    n_chk++;
    if (ld_rdy !== 1'b0)
      $display("FAIL skew_ldrdy: got %b want 0", ld_rdy);
    else n_pass++;
    ld_sel = 1'b1;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    n_chk++;
    if (arr_a !== wa || arr_b !== wb)
      $display("FAIL skew_t1: got %h %h want %h %h",
               arr_a, arr_b, wa, wb);
    else n_pass++;
    for (int e = 0; e < 40; e++) begin
      if (res_vld) break;
      @(posedge CLK);
      #1;
    end
    ld_vld = 1'b0;
    n_chk++;
    if (res_vld !== 1'b1 || res_data !== expect_c())
      $display("FAIL skew_result: got vld=%b %h want 1 %h",
               res_vld, res_data, expect_c());
    else n_pass++;
    finish_job();
  endtask

  task automatic test_random();
    int lat, nrst;
    logic seq;
    logic [RW-1:0] d;
    for (int it = 0; it < 6; it++) begin
      for (int b = 0; b < 4; b++)
        load(1'($urandom), int'($urandom_range(0, 3)),
             24'($urandom));
      run_job(lat, nrst, seq, d);
      n_chk++;
      if (d !== expect_c() || lat !== 9)
        $display("FAIL rand_job%0d: got %h lat %0d want %h lat 9",
                 it, d, lat, expect_c());
      else n_pass++;
      finish_job();
    end
  endtask

  initial begin
    n_chk   = 0;
    n_pass  = 0;
    rst_n   = 1'b0;
    ld_vld  = 1'b0;
    ld_sel  = 1'b0;
    ld_row  = '0;
    ld_data = '0;
    start   = 1'b0;
    res_rdy = 1'b0;
    clear_shadow();
    test_reset();
    test_identity();
    test_wrap();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_skew();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
